alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational `alu` datapath between two requesters, for example the integer issue path and the address/branch-compare path, so the core instantiates only one ALU. Each requester uses a valid/ready request channel and receives its result on a dedicated valid/ready response channel. A one-entry registered output stage gives 1-cycle latency and full throughput. Arbitration is round-robin, with fixed priority selectable at compile time.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width. Only 32 is supported, to match `alu`.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_op`  in  3  ALUControl encoding
- `req0_a`  in  XLEN  SrcA
- `req0_b`  in  XLEN  SrcB
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0, for requester 1
- `resp0_valid`  out  1  result pending for requester 0
- `resp0_ready`  in  1  requester 0 takes result
- `resp1_valid`  out  1  result pending for requester 1
- `resp1_ready`  in  1  requester 1 takes result
- `resp_result`  out  XLEN  registered ALUResult
- `resp_zero`  out  1  registered Zero flag

## Operation
- Op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SLL, 110 SRL: shift by the full 32-bit SrcB; a shift of 32 or more gives 0
  - 111 SLT: unsigned compare, result 1 or 0
- Output stage registers: `out_valid`, `out_id` (0/1), `out_result`, `out_zero`.
- `drain` = `out_valid` && `resp[out_id]_ready`.
- `can_accept` = !`out_valid` || `drain`.
- Grant is combinational from `req*_valid` and `last_id`:
  - only one requester valid: that requester wins
  - both valid: the requester ≠ `last_id` wins
- `reqN_ready` = `can_accept` && grant==N. At most one ready is high per cycle.
- Muxed op/a/b from the granted requester drive the `alu` instance.
- On accept: load `out_*` with the ALU outputs and the grant id, set `out_valid`, set `last_id` = grant.
- On drain with no accept: clear `out_valid`. Drain and accept together refill the register in the same cycle.
- `respN_valid` = `out_valid` && `out_id`==N.
- `resp_result` and `resp_zero` are shared and meaningful only while a `resp*_valid` is high.
- Requester rule: op, a and b stay stable while valid && !ready. The bench checks this with an assertion. The block does not buffer unaccepted requests.
- A requester may deassert valid before it is granted; the block ignores the dropped request.

## Timing
- Reset values:
  - `out_valid`=0, so `resp0_valid`=`resp1_valid`=0
  - `out_id`=0, `out_result`=0, `out_zero`=0
  - `last_id`=1, so requester 0 wins the first contention
- `req*_ready` may be high in the first cycle after reset deasserts.
- Latency: accept at edge N gives `resp_valid` high from N+1.
- Throughput: one operation per cycle while the destination response is ready.
- Backpressure: if the response is not taken, `out_*` holds and both `req*_ready` are 0.
- Reset asserted mid-operation discards the pending result, with no response issued.
- Simultaneous both-valid with a full, non-draining output: no grant, and `last_id` is unchanged.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as above.
- Macro undefined: fixed priority. Requester 0 always wins when both are valid, and `last_id` is neither used nor implemented.

## Structure
- Shared package `alu_pkg`:
  - ALUControl localparams `ALU_ADD`…`ALU_SLT` (000…111)
  - `XLEN`
  - the requester-id type
- `alu` and any other ALU users import these constants.
- One sub-module: the existing `alu`, instantiated once. The arbiter logic stays flat in `alu_arbiter`.

## Test plan
- Reset, then req0 ADD a=5 b=7 -> `req0_ready`=1 in the same cycle; next cycle `resp0_valid`=1, `resp_result`=12, `resp_zero`=0, `resp1_valid`=0.
- req0 SUB a=9 b=9 and req1 XOR a=0xF0 b=0x0F, both valid, both resp ready -> cycle 1 grants req0 (result 0, zero=1); cycle 2 grants req1 (result 0xFF). With `ALU_ARB_RR_EN` undefined and req0 kept valid, req1 waits.
- Continuous requests from both, both resp ready -> grants alternate 0,1,0,1 and one response per cycle with no bubbles.
- req1 SLL a=1 b=40 with `resp1_ready`=0 for 3 cycles -> `resp_result`=0 and `resp_zero`=1 held; both `req*_ready`=0; on release, drain and the next accept happen in the same cycle.
- SLT a=0xFFFFFFFF b=1 -> result 0 (unsigned). SRL a=0x80000000 b=31 -> result 1.
- Reset asserted while `out_valid`=1 -> next cycle both `resp*_valid`=0 and `last_id`=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU and its users.
//   XLEN         operand/result width (32 only)
//   ALU_ADD..SLT 3-bit ALUControl encodings
//   req_id_t     requester id carried alongside a result (0 or 1)
package alu_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef logic req_id_t;
endpackage

// File: rtl/alu.sv
// alu: purely combinational integer ALU.
//   alu_control in  3     ALUControl encoding (see alu_pkg)
//   src_a       in  XLEN  SrcA
//   src_b       in  XLEN  SrcB
//   alu_result  out XLEN  ALUResult
//   zero        out 1     ALUResult == 0
module alu
  import alu_pkg::*;
(
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);
  localparam int SHW = $clog2(XLEN);

  // Shift amount is the whole of src_b: any set bit above the low SHW bits
  // means the shift is >= XLEN and everything is shifted out.
  logic shift_out;
  assign shift_out = |src_b[XLEN-1:SHW];

  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLL: alu_result = shift_out ? '0 : (src_a << src_b[SHW-1:0]);
      ALU_SRL: alu_result = shift_out ? '0 : (src_a >> src_b[SHW-1:0]);
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two valid/ready requesters, with a
// one-entry registered output stage (1-cycle latency, full throughput).
//   clk, reset            clock, synchronous active-high reset
//   reqN_valid/ready      request handshake, N = 0/1
//   reqN_op/a/b           ALUControl, SrcA, SrcB of requester N
//   respN_valid/ready     response handshake towards requester N
//   resp_result/resp_zero shared registered result, valid with respN_valid
// Build option: ALU_ARB_RR_EN defined selects round-robin between the two
// requesters; undefined selects fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero
);
  import alu_pkg::*;

  logic            out_valid_q, out_valid_d;
  req_id_t         out_id_q, out_id_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            out_zero_q, out_zero_d;
`ifdef ALU_ARB_RR_EN
  req_id_t         last_id_q, last_id_d;
`endif

  logic            gnt_vld, drain, can_accept, accept;
  req_id_t         gnt_id;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic            alu_z;

  // Output register frees up when empty or when its holder takes it this cycle.
  assign drain      = out_valid_q && (out_id_q ? resp1_ready : resp0_ready);
  assign can_accept = !out_valid_q || drain;

  always_comb begin
    gnt_vld = req0_valid || req1_valid;
    gnt_id  = !req0_valid;        // fixed priority: 0 unless only 1 is asking
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) gnt_id = ~last_id_q;
`endif
  end

  assign accept     = gnt_vld && can_accept;
  assign req0_ready = accept && (gnt_id == 1'b0);
  assign req1_ready = accept && (gnt_id == 1'b1);

  assign alu_op = gnt_id ? req1_op : req0_op;
  assign alu_a  = gnt_id ? req1_a  : req0_a;
  assign alu_b  = gnt_id ? req1_b  : req0_b;

  alu u_alu (
    .alu_control (alu_op),
    .src_a       (alu_a),
    .src_b       (alu_b),
    .alu_result  (alu_y),
    .zero        (alu_z)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
`ifdef ALU_ARB_RR_EN
    last_id_d    = last_id_q;
`endif
    if (accept) begin
      // Covers drain+accept too: the register refills in the same cycle.
      out_valid_d  = 1'b1;
      out_id_d     = gnt_id;
      out_result_d = alu_y;
      out_zero_d   = alu_z;
`ifdef ALU_ARB_RR_EN
      last_id_d    = gnt_id;
`endif
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_id_q    <= 1'b1;   // requester 0 wins the first contention
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
`ifdef ALU_ARB_RR_EN
      last_id_q    <= last_id_d;
`endif
    end
  end

  assign resp0_valid = out_valid_q && (out_id_q == 1'b0);
  assign resp1_valid = out_valid_q && (out_id_q == 1'b1);
  assign resp_result = out_result_q;
  assign resp_zero   = out_zero_q;
endmodule
